hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline scheduler for the register-bank operand datapath.
- Tracks destination registers of in-flight instructions in the EX, DM and WB stages.
- Drives the register bank's operand-A/B forwarding selects and immediate select.
- Detects load-use hazards; issues a one-cycle stall and inserts a bubble into EX.
- Sits between decode and the register bank; feeds stall to fetch/decode.

Parameters:
- AW, 5, register address width
- R0_FWD_EN, 0, 1 = allow forwarding for register 0; 0 = register 0 never forwarded

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_ra  in  AW  source register A of decode instruction
- id_rb  in  AW  source register B of decode instruction
- id_use_a  in  1  instruction reads A
- id_use_b  in  1  instruction reads B (ignored when id_imm is 1)
- id_imm  in  1  operand B is the immediate
- id_rw  in  AW  destination register of decode instruction
- id_we  in  1  instruction writes a register
- id_load  in  1  instruction is a load (result valid at end of DM)
- flush  in  1  kill the decode instruction (branch taken)
- mux_sel_A  out  2  operand-A select
- mux_sel_B  out  2  operand-B select
- imm_sel  out  1  immediate select to register bank
- stall  out  1  hold PC and decode register this cycle
- RW_dm  out  AW  destination register currently in DM, for the register bank

Behaviour:
- Select encoding: 00 regfile, 01 ans_ex, 10 ans_dm, 11 ans_wb.
- State: three stage records {rw, we, load} for EX, DM and WB.
  - Each clock edge: WB<=DM, DM<=EX, EX<=decode record.
  - The decode record becomes a bubble (we=0, load=0) when stall=1, flush=1 or id_valid=0.
- Reset (async, rst_n=0): all stage we/load cleared, rw cleared to 0.
  - Outputs while in reset: mux_sel_A=00, mux_sel_B=00, imm_sel=0, stall=0, RW_dm=0.
- Outputs are combinational from the decode inputs and the registered stage records; no added latency.
- Match for a stage: stage.we=1, stage.rw==source, and (source!=0 or R0_FWD_EN=1).
- Forward priority per operand: EX (01) > DM (10) > WB (11) > regfile (00). The youngest producer wins.
- Operand A is considered only if id_valid and id_use_a; otherwise 00.
- Operand B is considered only if id_valid, id_use_b and !id_imm; otherwise 00.
- imm_sel = id_valid & id_imm.
- Load-use stall: stall=1 when EX.load=1 and EX matches a considered operand.
  - During a stall, sel outputs for that operand ignore EX and fall to DM/WB/regfile. They are don't-care to the datapath, but the value is fixed for verification.
  - The next cycle the load is in DM and the select becomes 10.
- flush=1: stall is forced to 0 and a bubble is inserted. flush has priority over stall.
- Back-to-back loads to the same register: each dependent consumer stalls exactly one cycle.
- RW_dm = DM.rw (registered).
- Write/read of the same register in the same cycle is handled by the WB forward (11); the regfile is never relied on for same-cycle bypass.
- Reset asserted mid-stall: stall drops immediately and all records are bubbles. After release, the first instruction sees regfile selects.

Test Plan:
- Reset: rst_n=0 with id_valid=1, id_ra=5 -> all outputs 0. Release, no prior writes -> mux_sel_A=00.
- EX forward: issue add r7 (we=1), next cycle id_ra=7, id_use_a=1 -> mux_sel_A=01, stall=0. One cycle later with a new reader of r7 -> 10. After that -> 11. Then -> 00.
- Priority: producers r6 in WB, DM and EX simultaneously; id_rb=6, id_use_b=1, id_imm=0 -> mux_sel_B=01.
- Load-use: load r3, next instruction reads r3 on A -> stall=1 for exactly one cycle, EX bubble inserted. Following cycle mux_sel_A=10, stall=0.
- Immediate and r0: id_imm=1 with id_rb matching EX rw -> mux_sel_B=00, imm_sel=1, no stall. Producer writes r0 with R0_FWD_EN=0, reader id_ra=0 -> mux_sel_A=00.
- Flush vs stall: load-use condition together with flush=1 -> stall=0. Next cycle EX.we=0, so a reader of that register gets no EX forward. Also pulse rst_n low during a stall -> stall=0 asynchronously.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding and load-use stall control for the register-bank datapath.
// Tracks EX/DM/WB destination records and resolves operand selects combinationally.
module hazard_fwd_ctrl #(
    parameter int unsigned AW        = 5,
    parameter bit          R0_FWD_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_ra,
    input  logic [AW-1:0] id_rb,
    input  logic          id_use_a,
    input  logic          id_use_b,
    input  logic          id_imm,
    input  logic [AW-1:0] id_rw,
    input  logic          id_we,
    input  logic          id_load,
    input  logic          flush,
    output logic [1:0]    mux_sel_A,
    output logic [1:0]    mux_sel_B,
    output logic          imm_sel,
    output logic          stall,
    output logic [AW-1:0] RW_dm
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_DM = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b11;

    typedef struct packed {
        logic [AW-1:0] rw;
        logic          we;
        logic          load;
    } stage_t;

    stage_t ex_q, dm_q, wb_q;
    stage_t dec_rec;

    logic use_a, use_b;
    logic ex_a, dm_a, wb_a;
    logic ex_b, dm_b, wb_b;
    logic hazard;

    // Producer match: register 0 is only a forwarding source when enabled.
    function automatic logic hit(input stage_t s, input logic [AW-1:0] src);
        return s.we && (s.rw == src) && ((src != '0) || R0_FWD_EN);
    endfunction

    always_comb begin
        use_a = id_valid & id_use_a;
        use_b = id_valid & id_use_b & ~id_imm;

        ex_a = use_a & hit(ex_q, id_ra);
        dm_a = use_a & hit(dm_q, id_ra);
        wb_a = use_a & hit(wb_q, id_ra);
        ex_b = use_b & hit(ex_q, id_rb);
        dm_b = use_b & hit(dm_q, id_rb);
        wb_b = use_b & hit(wb_q, id_rb);

        hazard = ex_q.load & (ex_a | ex_b);
        stall  = hazard & ~flush;

        // A load in EX has no result yet, so selects fall through to older stages.
        mux_sel_A = SEL_RF;
        if (ex_a && !ex_q.load) mux_sel_A = SEL_EX;
        else if (dm_a)          mux_sel_A = SEL_DM;
        else if (wb_a)          mux_sel_A = SEL_WB;

        mux_sel_B = SEL_RF;
        if (ex_b && !ex_q.load) mux_sel_B = SEL_EX;
        else if (dm_b)          mux_sel_B = SEL_DM;
        else if (wb_b)          mux_sel_B = SEL_WB;

        imm_sel = id_valid & id_imm & rst_n;
        RW_dm   = dm_q.rw;

        dec_rec.rw   = id_rw;
        dec_rec.we   = id_valid & id_we & ~stall & ~flush;
        dec_rec.load = id_valid & id_load & ~stall & ~flush;
    end

    // Stage record pipeline; stalled or flushed decode enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
            dm_q <= '0;
            wb_q <= '0;
        end else begin
            wb_q <= dm_q;
            dm_q <= ex_q;
            ex_q <= dec_rec;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding priority, load-use stall, flush and reset.
module tb_hazard_fwd_ctrl;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_ra;
    logic [AW-1:0] id_rb;
    logic          id_use_a;
    logic          id_use_b;
    logic          id_imm;
    logic [AW-1:0] id_rw;
    logic          id_we;
    logic          id_load;
    logic          flush;
    logic [1:0]    mux_sel_A;
    logic [1:0]    mux_sel_B;
    logic          imm_sel;
    logic          stall;
    logic [AW-1:0] RW_dm;

    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl #(.AW(AW), .R0_FWD_EN(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_ra     (id_ra),
        .id_rb     (id_rb),
        .id_use_a  (id_use_a),
        .id_use_b  (id_use_b),
        .id_imm    (id_imm),
        .id_rw     (id_rw),
        .id_we     (id_we),
        .id_load   (id_load),
        .flush     (flush),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .imm_sel   (imm_sel),
        .stall     (stall),
        .RW_dm     (RW_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_ra = '0; id_rb = '0; id_use_a = 1'b0; id_use_b = 1'b0;
        id_imm = 1'b0; id_rw = '0; id_we = 1'b0; id_load = 1'b0; flush = 1'b0;
    endtask

    // Writer of rd (optionally a load)
    task automatic prod(input logic [AW-1:0] rd, input logic ld);
        idle();
        id_valid = 1'b1; id_rw = rd; id_we = 1'b1; id_load = ld;
    endtask

    // Non-writing reader of ra on operand A
    task automatic read_a(input logic [AW-1:0] ra);
        idle();
        id_valid = 1'b1; id_ra = ra; id_use_a = 1'b1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        id_valid = 1'b1; id_ra = 5'd5; id_use_a = 1'b1; id_imm = 1'b1; id_we = 1'b1; id_rw = 5'd5;
        #3;
        chk("rst_selA", 8'(mux_sel_A), 8'h0);
        chk("rst_selB", 8'(mux_sel_B), 8'h0);
        chk("rst_imm", 8'(imm_sel), 8'h0);
        chk("rst_stall", 8'(stall), 8'h0);
        chk("rst_rwdm", 8'(RW_dm), 8'h0);
        next();
        next();
        rst_n = 1'b1;
        read_a(5'd5);
        #3;
        chk("post_rst_selA", 8'(mux_sel_A), 8'h0);

        // EX -> DM -> WB -> regfile forwarding of r7
        next(); prod(5'd7, 1'b0); #3;
        chk("c1_selA", 8'(mux_sel_A), 8'h0);
        next(); read_a(5'd7); #3;
        chk("fwd_ex_selA", 8'(mux_sel_A), 8'h1);
        chk("fwd_ex_stall", 8'(stall), 8'h0);
        next(); read_a(5'd7); #3;
        chk("fwd_dm_selA", 8'(mux_sel_A), 8'h2);
        chk("fwd_dm_rwdm", 8'(RW_dm), 8'h7);
        next(); read_a(5'd7); #3;
        chk("fwd_wb_selA", 8'(mux_sel_A), 8'h3);
        next(); read_a(5'd7); #3;
        chk("fwd_rf_selA", 8'(mux_sel_A), 8'h0);

        // r6 produced in three consecutive slots: youngest wins
        next(); prod(5'd6, 1'b0);
        next(); prod(5'd6, 1'b0);
        next(); prod(5'd6, 1'b0);
        next(); idle(); id_valid = 1'b1; id_rb = 5'd6; id_use_b = 1'b1; #3;
        chk("prio_ex_selB", 8'(mux_sel_B), 8'h1);
        chk("prio_selA_unused", 8'(mux_sel_A), 8'h0);
        next(); idle(); id_valid = 1'b1; id_rb = 5'd6; id_use_b = 1'b1; #3;
        chk("prio_dm_selB", 8'(mux_sel_B), 8'h2);

        // Load-use on r3: one stall cycle, then DM forward
        next(); prod(5'd3, 1'b1);
        next(); read_a(5'd3); #3;
        chk("lu_stall", 8'(stall), 8'h1);
        chk("lu_selA_during", 8'(mux_sel_A), 8'h0);
        next(); #3;
        chk("lu_stall_released", 8'(stall), 8'h0);
        chk("lu_selA_dm", 8'(mux_sel_A), 8'h2);
        next(); idle(); #3;
        chk("lu_after_stall", 8'(stall), 8'h0);
        chk("lu_after_selA", 8'(mux_sel_A), 8'h0);

        // Immediate operand B ignores a loading producer
        next(); prod(5'd9, 1'b1);
        next(); idle(); id_valid = 1'b1; id_rb = 5'd9; id_use_b = 1'b1; id_imm = 1'b1; #3;
        chk("imm_selB", 8'(mux_sel_B), 8'h0);
        chk("imm_sel", 8'(imm_sel), 8'h1);
        chk("imm_stall", 8'(stall), 8'h0);

        // r0 is never forwarded
        next(); prod(5'd0, 1'b0);
        next(); read_a(5'd0); #3;
        chk("r0_selA", 8'(mux_sel_A), 8'h0);

        // Flush beats stall and bubbles the decode record
        next(); prod(5'd4, 1'b1);
        next(); read_a(5'd4); flush = 1'b1; id_we = 1'b1; id_rw = 5'd4; #3;
        chk("flush_stall", 8'(stall), 8'h0);
        next(); read_a(5'd4); #3;
        chk("flush_no_ex_selA", 8'(mux_sel_A), 8'h2);
        chk("flush_next_stall", 8'(stall), 8'h0);

        // Asynchronous reset during a stall
        next(); prod(5'd8, 1'b1);
        next(); read_a(5'd8); #3;
        chk("rst_mid_stall_pre", 8'(stall), 8'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 8'(stall), 8'h0);
        chk("rst_mid_selA", 8'(mux_sel_A), 8'h0);
        next();
        rst_n = 1'b1;
        read_a(5'd8);
        #3;
        chk("rst_release_selA", 8'(mux_sel_A), 8'h0);
        chk("rst_release_stall", 8'(stall), 8'h0);
        chk("rst_release_rwdm", 8'(RW_dm), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
